// File: rtl/bit_serializer_pkg.sv
// Shared primitives for the bit_shift / bit_serializer family: shift
// direction codes, serializer state encoding and a constant clog2 helper.
package bit_serializer_pkg;

  localparam int DIR_MSB_FIRST = 0;
  localparam int DIR_LSB_FIRST = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Ceiling log2, usable in constant expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/single_entry_buffer.sv
// One-entry holding buffer: parks a word while the shifter is busy and
// generates the upstream ready from its occupancy flag alone.
module single_entry_buffer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic             i_rd,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_ready
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      // NOTE: the data register is reset too, so a cleared buffer never exposes a stale word.
      r_data <= '0;
    end else begin
      if (i_wr) begin
        r_data <= i_data;
      end
      if (i_wr) begin
        r_full <= 1'b1;
      end else if (i_rd) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_full  = r_full;
  assign o_ready = !r_full;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: splits each accepted word into SERIAL_WIDTH-bit
// beats, with a one-word holding buffer for gap-free back-to-back words.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter string ARCHITECTURE    = "BEHAVIORAL",
  parameter int    DATA_WIDTH      = 8,
  parameter int    SERIAL_WIDTH    = 1,
  parameter int    SHIFT_DIRECTION = DIR_MSB_FIRST
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_in_valid,
  output logic                    data_in_ready,
  output logic [SERIAL_WIDTH-1:0] data_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
  output logic                    data_out_first,
  output logic                    data_out_last
);

  localparam int BEATS = DATA_WIDTH / SERIAL_WIDTH;
  localparam int CW    = (clog2(BEATS) > 1) ? clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  if (DATA_WIDTH % SERIAL_WIDTH != 0) begin : g_bad_width
    $error("bit_serializer: SERIAL_WIDTH must divide DATA_WIDTH exactly");
  end
  if (ARCHITECTURE != "BEHAVIORAL") begin : g_bad_arch
    $error("bit_serializer: only the BEHAVIORAL architecture is defined");
  end

  state_e                  r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_shreg, w_shreg_nxt, w_shifted;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [SERIAL_WIDTH-1:0] w_beat;
  logic [DATA_WIDTH-1:0]   w_hold_data;
  logic                    w_busy, w_last, w_out_hs, w_in_hs, w_in_ready;
  logic                    w_slot_free, w_hold_full, w_drain, w_hold_wr;

  assign w_busy      = (r_state == ST_SHIFT);
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_out_hs    = w_busy && data_out_ready;
  assign w_in_hs     = data_in_valid && w_in_ready;
  assign w_slot_free = !w_busy || (w_out_hs && w_last);
  assign w_drain     = w_slot_free && w_hold_full;
  // A word goes to the buffer unless it can bypass straight into the shifter.
  assign w_hold_wr   = w_in_hs && (!w_slot_free || w_hold_full);

  single_entry_buffer #(
    .WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_hold_wr),
    .i_rd    (w_drain),
    .i_data  (data_in),
    .o_data  (w_hold_data),
    .o_full  (w_hold_full),
    .o_ready (w_in_ready)
  );

  if (SHIFT_DIRECTION == DIR_LSB_FIRST) begin : g_lsb_first
    assign w_beat    = r_shreg[SERIAL_WIDTH-1:0];
    assign w_shifted = r_shreg >> SERIAL_WIDTH;
  end else begin : g_msb_first
    assign w_beat    = r_shreg[DATA_WIDTH-1 -: SERIAL_WIDTH];
    assign w_shifted = r_shreg << SERIAL_WIDTH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    if (w_slot_free) begin
      if (w_hold_full) begin
        w_state_nxt = ST_SHIFT;
        w_shreg_nxt = w_hold_data;
        w_cnt_nxt   = '0;
      end else if (w_in_hs) begin
        w_state_nxt = ST_SHIFT;
        w_shreg_nxt = data_in;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else if (w_out_hs) begin
      w_shreg_nxt = w_shifted;
      w_cnt_nxt   = r_cnt + CW'(1);
    end
  end

  assign data_in_ready  = w_in_ready;
  assign data_out_valid = w_busy;
  assign data_out       = w_busy ? w_beat : '0;
  assign data_out_first = w_busy && (r_cnt == '0);
  assign data_out_last  = w_busy && w_last;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: four serializer configurations, each driven with
// directed and random traffic against a word-level queue model.
module tb_bit_serializer;

  typedef struct {
    logic [7:0] data;
    bit         first;
    bit         last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int S   = (g == 2) ? 4 : (g == 3) ? 8 : 1;
    localparam int DIR = (g == 1) ? 1 : 0;
    localparam int NB  = 8 / S;

    logic         rst_n;
    logic         vin;
    logic [7:0]   din;
    logic         oready;
    logic         in_ready, ov, of, ol;
    logic [S-1:0] dout;

    beat_t exp_q[$];
    int    outstanding;

    bit_serializer #(
      .ARCHITECTURE    ("BEHAVIORAL"),
      .DATA_WIDTH      (8),
      .SERIAL_WIDTH    (S),
      .SHIFT_DIRECTION (DIR)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_in        (din),
      .data_in_valid  (vin),
      .data_in_ready  (in_ready),
      .data_out       (dout),
      .data_out_valid (ov),
      .data_out_ready (oready),
      .data_out_first (of),
      .data_out_last  (ol)
    );

    // Beat k of word w, taken straight from the bit positions.
    function automatic int beat_of(input int w, input int k);
      int sh;
      sh = (DIR == 1) ? S * k : 8 - S * (k + 1);
      return (w >> sh) & ((1 << S) - 1);
    endfunction

    // Valid while any accepted word is unfinished; ready until two are.
    task automatic check_outputs(input string ph);
      check($sformatf("cfg%0d %s valid", g, ph), 32'(ov), 32'(outstanding >= 1));
      check($sformatf("cfg%0d %s in_ready", g, ph), 32'(in_ready), 32'(outstanding < 2));
      if (exp_q.size() != 0) begin
        check($sformatf("cfg%0d %s data", g, ph), 32'(dout), 32'(exp_q[0].data));
        check($sformatf("cfg%0d %s first", g, ph), 32'(of), 32'(exp_q[0].first));
        check($sformatf("cfg%0d %s last", g, ph), 32'(ol), 32'(exp_q[0].last));
      end else begin
        check($sformatf("cfg%0d %s idle_data", g, ph), 32'(dout), 32'd0);
        check($sformatf("cfg%0d %s idle_first", g, ph), 32'(of), 32'd0);
        check($sformatf("cfg%0d %s idle_last", g, ph), 32'(ol), 32'd0);
      end
    endtask

    task automatic step(input bit v, input int d, input bit r, output bit acc);
      beat_t b;
      vin    = v;
      din    = 8'(d);
      oready = r;
      acc    = v && (outstanding < 2);
      if (r && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        if (b.last) outstanding--;
      end
      if (acc) begin
        for (int k = 0; k < NB; k++) begin
          b.data  = 8'(beat_of(d, k));
          b.first = (k == 0);
          b.last  = (k == NB - 1);
          exp_q.push_back(b);
        end
        outstanding++;
      end
      @(posedge clk);
      #1;
      check_outputs("run");
    endtask

    task automatic send_word(input int w);
      bit acc;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) step(1'b1, w, 1'b1, acc);
    endtask

    task automatic drain();
      bit acc;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) step(1'b0, 0, 1'b1, acc);
      step(1'b0, 0, 1'b1, acc);
    endtask

    initial begin
      bit acc;
      rst_n       = 1'b0;
      vin         = 1'b0;
      din         = '0;
      oready      = 1'b0;
      outstanding = 0;
      @(posedge clk);
      #1;
      check_outputs("reset");
      #3 rst_n = 1'b1;

      case (g)
        0: send_word('hA5);
        1: send_word('h35);
        2: begin send_word('h0F); send_word('hF0); send_word('h3C); end
        default: for (int w = 1; w <= 4; w++) send_word(w);
      endcase
      drain();

      // Stall at beat 3 of the first word while the second waits in hold.
      step(1'b1, 'hA5, 1'b1, acc);
      step(1'b1, 'h3C, 1'b1, acc);
      step(1'b0, 0, 1'b1, acc);
      step(1'b0, 0, 1'b1, acc);
      repeat (5) step(1'b0, 0, 1'b0, acc);
      drain();

      for (int i = 0; i < 60; i++) step(1'b1, int'($urandom_range(0, 255)), 1'b1, acc);
      for (int i = 0; i < 400; i++)
        step($urandom_range(0, 99) < 70, int'($urandom_range(0, 255)),
             $urandom_range(0, 99) < 75, acc);
      drain();

      // Asynchronous reset mid-word with the holding buffer occupied.
      step(1'b1, 'hA5, 1'b1, acc);
      step(1'b1, 'h5A, 1'b1, acc);
      repeat (3) step(1'b0, 0, 1'b1, acc);
      #2;
      rst_n = 1'b0;
      vin   = 1'b0;
      exp_q.delete();
      outstanding = 0;
      #1;
      check_outputs("async_reset");
      @(posedge clk);
      #1;
      check_outputs("in_reset");
      rst_n = 1'b1;
      send_word('h81);
      drain();

      n_done++;
    end
  end

  initial begin
    for (int c = 0; c < 20000 && n_done < 4; c++) @(posedge clk);
    if (n_done < 4) check("completion", 32'(n_done), 32'd4);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial stage that sits directly downstream of `bit_shift`. It accepts `DATA_WIDTH`-bit words on a valid/ready interface and emits each word as `DATA_WIDTH/SERIAL_WIDTH` consecutive `SERIAL_WIDTH`-bit beats, MSB-first or LSB-first. A one-entry holding buffer gives gap-free output across back-to-back words, and the output side honours backpressure.

## Interface
- `ARCHITECTURE`, "BEHAVIORAL", implementation select; only "BEHAVIORAL" is defined.
- `DATA_WIDTH`, 8, input word width.
- `SERIAL_WIDTH`, 1, output beat width; must divide `DATA_WIDTH` exactly, otherwise elaboration fails.
- `SHIFT_DIRECTION`, 0, 0 = MSB-first (shift left); 1 = LSB-first (shift right).
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `data_in`  in  `DATA_WIDTH`  parallel word (normally `bit_shift` `data_out`).
- `data_in_valid`  in  1  `data_in` is valid.
- `data_in_ready`  out  1  block can accept a word.
- `data_out`  out  `SERIAL_WIDTH`  current beat; 0 when `data_out_valid` is low.
- `data_out_valid`  out  1  beat is valid.
- `data_out_ready`  in  1  downstream accepts the beat.
- `data_out_first`  out  1  beat 0 of a word (qualified by valid).
- `data_out_last`  out  1  final beat of a word (qualified by valid).

## Operation
- `BEATS = DATA_WIDTH/SERIAL_WIDTH`. The beat counter is `max(1, clog2(BEATS))` bits wide.
- State is held in:
  - shift register `shreg` plus a `busy` flag;
  - holding buffer `hold` plus a `hold_full` flag;
  - beat counter `cnt`.
- Two states:
  - IDLE: `busy=0`.
  - SHIFT: `busy=1`.
- Handshakes:
  - Input handshake: `data_in_valid && data_in_ready`.
  - Output handshake: `data_out_valid && data_out_ready`.
- `data_in_ready = !hold_full`. It is combinational from state only and never depends on `data_out_ready`.
- `data_out_valid = busy`. `data_out_first = busy && cnt==0`. `data_out_last = busy && cnt==BEATS-1`.
- Output beat selection:
  - `SHIFT_DIRECTION=0`: `data_out = shreg[DATA_WIDTH-1 -: SERIAL_WIDTH]`, and `shreg` shifts left by `SERIAL_WIDTH` on each non-last output handshake.
  - `SHIFT_DIRECTION=1`: `data_out = shreg[SERIAL_WIDTH-1:0]`, and `shreg` shifts right.
- "Load slot free" means `!busy`, or an output handshake on the last beat in this cycle.
- Load priority when the load slot is free:
  - `hold_full`: `hold` moves to `shreg`, `cnt` goes to 0, `hold_full` is cleared.
  - Otherwise, if an input handshake occurs: bypass, `data_in` goes straight to `shreg`, `cnt` goes to 0.
  - Otherwise: `busy` goes to 0 (IDLE).
- Input handshake when the load slot is not free, or when `hold_full` is being drained this cycle: the word is written to `hold`.
- Non-last output handshake: `cnt` increments by 1. The counter never wraps mid-word.
- Backpressure: while `data_out_valid && !data_out_ready`, the values of `data_out`, `cnt`, first and last are held unchanged.
- Word order is strictly FIFO. No word is dropped or duplicated.
- Reset (asserted at any time, including mid-word):
  - `busy=0`, `hold_full=0`, `cnt=0`, `shreg=0`, `hold=0`.
  - Any partial word is discarded.
  - Outputs: `data_out=0`, `data_out_valid=0`, first=0, last=0, `data_in_ready=1`.

## Timing
- Latency: a word accepted in cycle N from IDLE presents beat 0 in cycle N+1.
- Throughput: with `data_out_ready=1` and continuous input, one beat every cycle with no bubbles between words, including `BEATS=1`.
- `data_in_ready` deasserts the cycle after `hold` fills. It reasserts the cycle after `hold` drains into `shreg`.
- Simultaneous last-beat handshake and `hold_full`: `hold` loads and `data_in_ready` is 1 on the next cycle.
- No combinational path from `data_in_valid` or `data_out_ready` to `data_in_ready`.

## Structure
- Shared primitives package/header holds:
  - `DIR_MSB_FIRST=0` and `DIR_LSB_FIRST=1`, also used by `bit_shift`;
  - state encodings `ST_IDLE` and `ST_SHIFT`;
  - the `clog2` function.
- One sub-module: `single_entry_buffer` (`hold` register, `hold_full` flag, ready generation). The shifter and counter stay in `bit_serializer`.

## Test plan
- W=8, S=1, dir 0, `data_in=0xA5`, ready=1 → beats 1,0,1,0,0,1,0,1 in cycles N+1..N+8; first at N+1, last at N+8; valid=0 at N+9.
- W=8, S=1, dir 1, `data_in=0x35` → beats 1,0,1,0,1,1,0,0.
- W=8, S=4, dir 0, back-to-back 0x0F, 0xF0, 0x3C → nibbles 0,F,F,0,3,C in 6 consecutive cycles; `data_in_ready` drops when `hold` fills.
- W=8, S=1, `data_out_ready` low for 5 cycles at beat 3 of 0xA5 → `data_out`, first/last and `cnt` held; word completes intact; the second word waits in `hold`.
- W=8, S=8, continuous input 0x01..0x04 with ready=1 → one word per cycle, first=last=1 on every beat, no gaps.
- `rst_n` pulsed low at beat 4 of 0xA5 with `hold` full → all outputs 0 asynchronously, `data_in_ready=1`; the next word 0x81 starts cleanly at beat 0.
